// File: rtl/mem_bank_nrw.sv
// rtl/mem_bank_nrw.sv - N-port byte-masked register bank with init clear, registered reads and collision counting
// MEM_BANK_NRW_BYPASS_EN selects write-first same-cycle reads; undefined gives read-first.
module mem_bank_nrw #(
  parameter int NUM_PORTS = 2,
  parameter int REG_DEPTH = 4,
  parameter int REG_WIDTH = 64,
  parameter int CNT_WIDTH = 16,
  localparam int AW = $clog2(REG_DEPTH),
  localparam int BW = REG_WIDTH / 8
) (
  input  logic                           RW_clk,
  input  logic                           RW_reset,
  input  logic [NUM_PORTS-1:0]           RW_en,
  input  logic [NUM_PORTS-1:0]           RW_wmode,
  input  logic [NUM_PORTS*AW-1:0]        RW_addr,
  input  logic [NUM_PORTS*REG_WIDTH-1:0] RW_wdata,
  input  logic [NUM_PORTS*BW-1:0]        RW_wmask,
  output logic [NUM_PORTS*REG_WIDTH-1:0] RW_rdata,
  output logic [NUM_PORTS-1:0]           RW_rvalid,
  output logic                           init_busy,
  output logic                           collision,
  output logic [CNT_WIDTH-1:0]           collision_cnt
);

  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

  state_t                 state, next_state;
  logic [AW-1:0]          ptr;
  logic [REG_WIDTH-1:0]   mem    [REG_DEPTH];
  logic [REG_WIDTH-1:0]   merged [REG_DEPTH];
  logic [AW-1:0]          addr_p [NUM_PORTS];
  logic [NUM_PORTS-1:0]   wr_en, rd_en;
  logic                   collide;

  always_ff @(posedge RW_clk) begin
    if (RW_reset) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= next_state;
      if (state == INIT) ptr <= ptr + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    if (state == INIT && ptr == AW'(REG_DEPTH - 1)) next_state = READY;
  end

  always_comb begin
    init_busy = (state == INIT);
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      addr_p[i] = RW_addr[i*AW +: AW];
      wr_en[i]  = (state == READY) && RW_en[i] && RW_wmode[i];
      rd_en[i]  = (state == READY) && RW_en[i] && !RW_wmode[i];
    end
  end

  // Apply ports highest index first so the lowest index overwrites contested bytes.
  always_comb begin
    for (int a = 0; a < REG_DEPTH; a++) begin
      merged[a] = mem[a];
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (wr_en[i] && addr_p[i] == AW'(a)) begin
          for (int b = 0; b < BW; b++) begin
            if (RW_wmask[i*BW + b]) merged[a][b*8 +: 8] = RW_wdata[i*REG_WIDTH + b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = i + 1; j < NUM_PORTS; j++) begin
        if (wr_en[i] && wr_en[j] && addr_p[i] == addr_p[j] &&
            (RW_wmask[i*BW +: BW] & RW_wmask[j*BW +: BW]) != '0)
          collide = 1'b1;
      end
    end
  end

  always_ff @(posedge RW_clk) begin
    if (!RW_reset) begin
      if (state == INIT) begin
        mem[ptr] <= '0;
      end else begin
        for (int a = 0; a < REG_DEPTH; a++) mem[a] <= merged[a];
      end
    end
  end

  always_ff @(posedge RW_clk) begin
    if (RW_reset) begin
      RW_rdata  <= '0;
      RW_rvalid <= '0;
    end else begin
      RW_rvalid <= rd_en;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (rd_en[i]) begin
`ifdef MEM_BANK_NRW_BYPASS_EN
          RW_rdata[i*REG_WIDTH +: REG_WIDTH] <= merged[addr_p[i]];
`else
          RW_rdata[i*REG_WIDTH +: REG_WIDTH] <= mem[addr_p[i]];
`endif
        end
      end
    end
  end

  always_ff @(posedge RW_clk) begin
    if (RW_reset) begin
      collision     <= 1'b0;
      collision_cnt <= '0;
    end else begin
      collision <= collide;
      if (collide && collision_cnt != '1) collision_cnt <= collision_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bank_nrw.sv
// tb/tb_mem_bank_nrw.sv - directed self-checking bench for mem_bank_nrw (CNT_WIDTH=2)
module tb_mem_bank_nrw;
  localparam int NP = 2;
  localparam int D  = 4;
  localparam int W  = 64;
  localparam int CW = 2;
  localparam int AW = 2;
  localparam int BW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     en, wmode;
  logic [NP*AW-1:0]  addr;
  logic [NP*W-1:0]   wdata;
  logic [NP*BW-1:0]  wmask;
  logic [NP*W-1:0]   rdata;
  logic [NP-1:0]     rvalid;
  logic              busy, coll;
  logic [CW-1:0]     ccnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bank_nrw #(.NUM_PORTS(NP), .REG_DEPTH(D), .REG_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .RW_clk(clk), .RW_reset(rst), .RW_en(en), .RW_wmode(wmode), .RW_addr(addr),
    .RW_wdata(wdata), .RW_wmask(wmask), .RW_rdata(rdata), .RW_rvalid(rvalid),
    .init_busy(busy), .collision(coll), .collision_cnt(ccnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = '0; wmode = '0; addr = '0; wdata = '0; wmask = '0;
  endtask

  task automatic drive(input int p, input logic e, input logic wm, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic [BW-1:0] m);
    en[p] = e;
    wmode[p] = wm;
    addr[p*AW +: AW] = a;
    wdata[p*W +: W] = d;
    wmask[p*BW +: BW] = m;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step(); step();
    chk("rst_busy", busy, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata[127:64] | rdata[63:0], 0);
    chk("rst_coll", coll, 0);
    chk("rst_cnt", ccnt, 0);

    rst = 1'b0;
    drive(0, 1, 0, 2'd0, '0, '0);
    for (int k = 1; k <= D; k++) begin
      step();
      chk($sformatf("init_busy_%0d", k), busy, (k < D) ? 1 : 0);
      chk($sformatf("init_rvalid_%0d", k), rvalid, 0);
    end

    for (int a = 0; a < D; a++) begin
      drive(0, 1, 0, AW'(a), '0, '0);
      drive(1, 1, 0, AW'(3 - a), '0, '0);
      step();
      chk($sformatf("clr_rd0_%0d", a), rdata[63:0], 0);
      chk($sformatf("clr_rd1_%0d", a), rdata[127:64], 0);
      chk($sformatf("clr_rv_%0d", a), rvalid, 2'b11);
    end
    idle();
    step();
    chk("rvalid_pulse", rvalid, 0);

    drive(0, 1, 1, 2'd2, 64'h1111_2222_3333_4444, 8'hFF);
    step();
    idle();
    drive(1, 1, 0, 2'd2, '0, '0);
    step();
    chk("wr_rd_data", rdata[127:64], 64'h1111_2222_3333_4444);
    chk("wr_rd_valid", rvalid, 2'b10);
    chk("wr_no_coll", coll, 0);
    idle();
    step();
    chk("rdata_hold", rdata[127:64], 64'h1111_2222_3333_4444);

    drive(0, 1, 1, 2'd1, {8{8'hAA}}, 8'h0F);
    drive(1, 1, 1, 2'd1, {8{8'hBB}}, 8'hFF);
    step();
    chk("coll_pulse", coll, 1);
    chk("coll_cnt1", ccnt, 1);
    idle();
    drive(0, 1, 0, 2'd1, '0, '0);
    step();
    chk("prio_data", rdata[63:0], 64'hBBBB_BBBB_AAAA_AAAA);
    chk("coll_drop", coll, 0);
    chk("coll_cnt_hold", ccnt, 1);

    idle();
    drive(0, 1, 1, 2'd0, {8{8'hCC}}, 8'h0F);
    drive(1, 1, 1, 2'd0, {8{8'hDD}}, 8'hF0);
    step();
    chk("disj_no_coll", coll, 0);
    chk("disj_cnt", ccnt, 1);
    idle();
    drive(0, 1, 0, 2'd0, '0, '0);
    step();
    chk("disj_data", rdata[63:0], 64'hDDDD_DDDD_CCCC_CCCC);

    idle();
    drive(0, 1, 1, 2'd2, {8{8'hFF}}, 8'h00);
    drive(1, 1, 1, 2'd2, {8{8'hEE}}, 8'h00);
    step();
    chk("zmask_no_coll", coll, 0);
    idle();
    drive(1, 1, 0, 2'd2, '0, '0);
    step();
    chk("zmask_data", rdata[127:64], 64'h1111_2222_3333_4444);

    idle();
    drive(0, 1, 1, 2'd3, 64'h5, 8'hFF);
    drive(1, 1, 0, 2'd3, '0, '0);
    step();
`ifdef MEM_BANK_NRW_BYPASS_EN
    chk("rw_same_cycle", rdata[127:64], 64'h5);
`else
    chk("rw_same_cycle", rdata[127:64], 64'h0);
`endif
    idle();
    drive(1, 1, 0, 2'd3, '0, '0);
    step();
    chk("rw_after", rdata[127:64], 64'h5);

    idle();
    rst = 1'b1;
    step();
    chk("rst2_busy", busy, 1);
    chk("rst2_cnt", ccnt, 0);
    chk("rst2_rdata", rdata[127:64], 0);
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    chk("midinit_busy", busy, 1);
    rst = 1'b0;
    for (int k = 1; k < D; k++) begin
      step();
      chk($sformatf("restart_busy_%0d", k), busy, 1);
    end
    step();
    chk("restart_done", busy, 0);
    drive(0, 1, 0, 2'd1, '0, '0);
    drive(1, 1, 0, 2'd3, '0, '0);
    step();
    chk("reclr_rd0", rdata[63:0], 0);
    chk("reclr_rd1", rdata[127:64], 0);

    idle();
    drive(0, 1, 1, 2'd0, 64'h1, 8'h01);
    drive(1, 1, 1, 2'd0, 64'h2, 8'h01);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("sat_cnt_%0d", k), ccnt, (k < 3) ? k : 3);
    end
    chk("sat_coll", coll, 1);
    idle();
    drive(0, 1, 0, 2'd0, '0, '0);
    step();
    chk("sat_final", ccnt, 3);
    chk("sat_coll_drop", coll, 0);
    chk("sat_winner", rdata[63:0], 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
